// File: rtl/state_predict_engine_pkg.sv
// ----------------------------------------------------------------------------
// kf_pkg - shared types and helpers for the Kalman state-prediction engine.
//   state_t      : default-width signed fixed-point element
//   fsm_state_t  : engine FSM encoding
//   ceil_div     : integer ceiling division (row-group count)
//   sat_round    : round-to-nearest, arithmetic shift by FRAC, saturate to
//                  DWIDTH bits, report clipping
// ----------------------------------------------------------------------------
package kf_pkg;

  localparam int unsigned DWIDTH_DEF = 64;
  localparam int unsigned FRAC_DEF   = 32;
  localparam int unsigned N_DEF      = 12;
  localparam int unsigned LANES_DEF  = 4;

  // Working width for sat_round; must cover the accumulator plus one bit
  // and DWIDTH+FRAC for the shifted bias term.
  localparam int unsigned SR_W = 256;

  typedef logic signed [DWIDTH_DEF-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WRITE,
    ST_FIN
  } fsm_state_t;

  typedef struct packed {
    logic signed [SR_W-1:0] val;
    logic                   ovf;
  } sr_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic sr_t sat_round(input logic signed [SR_W-1:0] s,
                                    input int unsigned            dw,
                                    input int unsigned            frac);
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    sr_t                    o;
    r = s;
    if (frac > 0) r = r + $signed(SR_W'(1) << (frac - 1));
    r  = r >>> frac;
    hi = $signed((SR_W'(1) << (dw - 1)) - SR_W'(1));
    lo = ~hi;
    o.val = r;
    o.ovf = 1'b0;
    if (r > hi) begin
      o.val = hi;
      o.ovf = 1'b1;
    end else if (r < lo) begin
      o.val = lo;
      o.ovf = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/state_predict_engine_if.sv
// ----------------------------------------------------------------------------
// state_predict_engine_if - request/result bundle of the prediction engine.
//   start, bias_en        : run request and bias select (master -> engine)
//   f_mat[row][col]       : transition matrix F
//   x_in, bu_in           : state X_kk and control term Bu
//   x_pred                : predicted state X_k1k (engine -> master)
//   busy, done, ovf       : run status, completion pulse, sticky saturation
// ----------------------------------------------------------------------------
interface state_predict_engine_if #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned N      = 12
);

  logic                              start;
  logic                              bias_en;
  logic [N-1:0][N-1:0][DWIDTH-1:0]   f_mat;
  logic [N-1:0][DWIDTH-1:0]          x_in;
  logic [N-1:0][DWIDTH-1:0]          bu_in;
  logic [N-1:0][DWIDTH-1:0]          x_pred;
  logic                              busy;
  logic                              done;
  logic                              ovf;

  modport master (
    output start, bias_en, f_mat, x_in, bu_in,
    input  x_pred, busy, done, ovf
  );

  modport slave (
    input  start, bias_en, f_mat, x_in, bu_in,
    output x_pred, busy, done, ovf
  );

endinterface

// File: rtl/state_predict_engine_mac_lane.sv
// ----------------------------------------------------------------------------
// mac_lane - one multiply-accumulate lane of the prediction engine.
//   clk, rst   : clock, async active-high reset
//   i_clr      : clear accumulator (priority over accumulate)
//   i_acc_en   : acc += i_f * i_x (full precision)
//   i_bu       : control term for this lane's row, i_bias_en selects it
//   o_res      : bias + round + saturate of the accumulator (combinational)
//   o_ovf      : o_res was clipped
// ----------------------------------------------------------------------------
module mac_lane
  import kf_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int unsigned N      = N_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_acc_en,
  input  logic signed [DWIDTH-1:0] i_f,
  input  logic signed [DWIDTH-1:0] i_x,
  input  logic signed [DWIDTH-1:0] i_bu,
  input  logic                     i_bias_en,
  output logic signed [DWIDTH-1:0] o_res,
  output logic                     o_ovf
);

  localparam int unsigned PW = 2 * DWIDTH;
  localparam int unsigned AW = PW + $clog2(N) + 1;

  logic signed [PW-1:0]   w_prod;
  logic signed [AW-1:0]   r_acc;
  logic signed [SR_W-1:0] w_acc_ext;
  logic signed [SR_W-1:0] w_bias;
  logic signed [SR_W-1:0] w_sum;
  sr_t                    w_sr;

  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign w_prod = {{DWIDTH{i_f[DWIDTH-1]}}, i_f} * {{DWIDTH{i_x[DWIDTH-1]}}, i_x};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
    end
  end

  // Bias is aligned to the accumulator's 2*FRAC scale before rounding.
  assign w_acc_ext = {{(SR_W-AW){r_acc[AW-1]}}, r_acc};
  assign w_bias    = i_bias_en ? ({{(SR_W-DWIDTH){i_bu[DWIDTH-1]}}, i_bu} << FRAC) : '0;
  assign w_sum     = w_acc_ext + w_bias;
  assign w_sr      = sat_round(w_sum, DWIDTH, FRAC);
  assign o_res     = w_sr.val[DWIDTH-1:0];
  assign o_ovf     = w_sr.ovf;

endmodule

// File: rtl/state_predict_engine.sv
// ----------------------------------------------------------------------------
// state_predict_engine - X_k1k = F * X_kk (+ Bu) in signed fixed point.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of state_predict_engine_if (start/bias_en/f_mat/
//              x_in/bu_in in, x_pred/busy/done/ovf out)
// LANES MAC lanes are time-multiplexed over ceil(N/LANES) row groups; each
// group takes N accumulate cycles plus one write cycle. Inputs are captured
// on the accepted start so upstream may change them during a run.
// ----------------------------------------------------------------------------
module state_predict_engine
  import kf_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned FRAC   = FRAC_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned LANES  = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  state_predict_engine_if.slave bus
);

  localparam int unsigned G  = ceil_div(N, LANES);
  localparam int unsigned NP = G * LANES;
  localparam int unsigned GW = $clog2(G + 1);
  localparam int unsigned JW = $clog2(N);

  fsm_state_t                       r_state;
  logic [GW-1:0]                    r_g;
  logic [JW-1:0]                    r_j;
  // Snapshots padded to NP rows so padded lanes read zeros.
  logic [NP-1:0][N-1:0][DWIDTH-1:0] r_f;
  logic [NP-1:0][DWIDTH-1:0]        r_bu;
  logic [N-1:0][DWIDTH-1:0]         r_x;
  logic                             r_bias;
  logic [N-1:0][DWIDTH-1:0]         r_xpred;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_ovf;

  logic signed [DWIDTH-1:0]         w_x_j;
  logic signed [DWIDTH-1:0]         w_lf  [LANES];
  logic signed [DWIDTH-1:0]         w_lbu [LANES];
  logic signed [DWIDTH-1:0]         w_res [LANES];
  logic [LANES-1:0]                 w_lovf;
  logic                             w_clr;
  logic                             w_acc_en;
  logic                             w_last_j;
  logic                             w_last_g;

  assign w_x_j    = r_x[r_j];
  assign w_clr    = (r_state == ST_WRITE) || (r_state == ST_IDLE);
  assign w_acc_en = (r_state == ST_MAC);
  assign w_last_j = (r_j == JW'(N - 1));
  assign w_last_g = (r_g == GW'(G - 1));

  // Per-lane operand select for the current row group.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lf[l]  = '0;
      w_lbu[l] = '0;
      for (int unsigned g = 0; g < G; g++) begin
        if (r_g == GW'(g)) begin
          w_lf[l]  = r_f[g*LANES+l][r_j];
          w_lbu[l] = r_bu[g*LANES+l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .DWIDTH (DWIDTH),
      .FRAC   (FRAC),
      .N      (N)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_acc_en  (w_acc_en),
      .i_f       (w_lf[l]),
      .i_x       (w_x_j),
      .i_bu      (w_lbu[l]),
      .i_bias_en (r_bias),
      .o_res     (w_res[l]),
      .o_ovf     (w_lovf[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_j     <= '0;
      r_f     <= '0;
      r_bu    <= '0;
      r_x     <= '0;
      r_bias  <= 1'b0;
      r_xpred <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_f          <= '0;
            r_f[N-1:0]   <= bus.f_mat;
            r_bu         <= '0;
            r_bu[N-1:0]  <= bus.bu_in;
            r_x          <= bus.x_in;
            r_bias       <= bus.bias_en;
            r_ovf        <= 1'b0;
            r_g          <= '0;
            r_j          <= '0;
            r_busy       <= 1'b1;
            r_state      <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (w_last_j) begin
            r_state <= ST_WRITE;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        ST_WRITE: begin
          // Walk rows rather than lanes so padded lanes never touch x_pred.
          for (int unsigned r = 0; r < N; r++) begin
            if (r_g == GW'(r / LANES)) begin
              r_xpred[r] <= w_res[r % LANES];
              if (w_lovf[r % LANES]) r_ovf <= 1'b1;
            end
          end
          r_j <= '0;
          if (w_last_g) begin
            r_state <= ST_FIN;
          end else begin
            r_g     <= r_g + 1'b1;
            r_state <= ST_MAC;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.x_pred = r_xpred;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_state_predict_engine.sv
// ----------------------------------------------------------------------------
// tb_state_predict_engine - directed self-checking bench.
// Instance A: N=12, LANES=4 (Q32.32). Instance B: N=5, LANES=2 (padded lane).
// Edge 0 is the rising edge that samples start; outputs are sampled 1 time
// unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_state_predict_engine;
  import kf_pkg::*;

  localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  state_predict_engine_if #(.DWIDTH(64), .N(12)) ifa ();
  state_predict_engine_if #(.DWIDTH(64), .N(5))  ifb ();

  state_predict_engine #(.DWIDTH(64), .FRAC(32), .N(12), .LANES(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  state_predict_engine #(.DWIDTH(64), .FRAC(32), .N(5), .LANES(2)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );

  task automatic clear_a();
    ifa.start = 1'b0; ifa.bias_en = 1'b0;
    ifa.f_mat = '0; ifa.x_in = '0; ifa.bu_in = '0;
  endtask

  task automatic load_identity_a();
    clear_a();
    for (int i = 0; i < 12; i++) begin
      ifa.f_mat[i][i] = ONE;
      ifa.x_in[i]     = 64'(i + 1) << 32;
    end
  endtask

  task automatic run_a(input int budget, output int first_edge, output int cnt);
    first_edge = -1; cnt = 0;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (ifa.done) begin
        if (first_edge < 0) first_edge = k;
        cnt++;
      end
    end
  endtask

  task automatic run_b(input int budget, output int first_edge, output int cnt);
    first_edge = -1; cnt = 0;
    @(negedge clk) ifb.start = 1'b1;
    @(posedge clk); #1 ifb.start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (ifb.done) begin
        if (first_edge < 0) first_edge = k;
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    clear_a();
    ifb.start = 1'b0; ifb.bias_en = 1'b0; ifb.f_mat = '0; ifb.x_in = '0; ifb.bu_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ifa.busy, ifa.done, ifa.ovf} !== 3'b000) begin
      errors++; $display("FAIL reset_a_flags: got %b expected 000", {ifa.busy, ifa.done, ifa.ovf});
    end
    checks++;
    if (ifa.x_pred !== '0) begin
      errors++; $display("FAIL reset_a_xpred: got %h expected 0", ifa.x_pred);
    end
    checks++;
    if ({ifb.busy, ifb.done, ifb.ovf} !== 3'b000 || ifb.x_pred !== '0) begin
      errors++; $display("FAIL reset_b: got flags %b xpred %h expected 0",
                         {ifb.busy, ifb.done, ifb.ovf}, ifb.x_pred);
    end
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_identity();
    int fe, cnt;
    load_identity_a();
    run_a(50, fe, cnt);
    checks++;
    if (fe !== 40) begin errors++; $display("FAIL ident_done_edge: got %0d expected 40", fe); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL ident_done_width: got %0d expected 1", cnt); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ifa.x_pred[i] !== 64'(i + 1) << 32) begin
        errors++; $display("FAIL ident_row%0d: got %h expected %h", i, ifa.x_pred[i], 64'(i + 1) << 32);
      end
    end
    checks++;
    if ({ifa.ovf, ifa.busy} !== 2'b00) begin
      errors++; $display("FAIL ident_ovf_busy: got %b expected 00", {ifa.ovf, ifa.busy});
    end
  endtask

  task automatic test_bias_partial();
    int fe, cnt;
    state_t xv  [5];
    state_t exv [5];
    xv  = '{64'sd4294967296, -64'sd8589934592, 64'sd12884901888, -64'sd17179869184, 64'sd2147483648};
    exv = '{64'sd9663676416, -64'sd16106127360, 64'sd26843545600, -64'sd33285996544, 64'sd5368709120};
    ifb.f_mat = '0;
    for (int i = 0; i < 5; i++) begin
      ifb.f_mat[i][i] = 64'sd8589934592;
      ifb.x_in[i]     = xv[i];
      ifb.bu_in[i]    = 64'sd1073741824;
    end
    ifb.bias_en = 1'b1;
    run_b(30, fe, cnt);
    ifb.bias_en = 1'b0;
    checks++;
    if (fe !== 19 || cnt !== 1) begin
      errors++; $display("FAIL bias_done: got edge %0d count %0d expected edge 19 count 1", fe, cnt);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifb.x_pred[i] !== exv[i]) begin
        errors++; $display("FAIL bias_row%0d: got %h expected %h", i, ifb.x_pred[i], exv[i]);
      end
    end
    checks++;
    if (ifb.ovf !== 1'b0) begin errors++; $display("FAIL bias_ovf: got %b expected 0", ifb.ovf); end
  endtask

  task automatic test_saturation();
    int fe, cnt;
    clear_a();
    ifa.f_mat[0][0] = 64'h4000_0000_0000_0000;
    ifa.x_in[0]     = 64'h4000_0000_0000_0000;
    run_a(45, fe, cnt);
    checks++;
    if (ifa.x_pred[0] !== 64'h7FFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL sat_pos_row0: got %h expected 7fffffffffffffff", ifa.x_pred[0]);
    end
    checks++;
    if (ifa.ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b expected 1", ifa.ovf); end
    checks++;
    if (ifa.x_pred[11:1] !== '0) begin
      errors++; $display("FAIL sat_other_rows: got %h expected 0", ifa.x_pred[11:1]);
    end
    ifa.x_in[0] = 64'hC000_0000_0000_0000;
    run_a(45, fe, cnt);
    checks++;
    if (ifa.x_pred[0] !== 64'h8000_0000_0000_0000 || ifa.ovf !== 1'b1) begin
      errors++; $display("FAIL sat_neg: got %h ovf %b expected 8000000000000000 ovf 1",
                         ifa.x_pred[0], ifa.ovf);
    end
    load_identity_a();
    run_a(45, fe, cnt);
    checks++;
    if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL sat_clean_ovf: got %b expected 0", ifa.ovf); end
  endtask

  task automatic test_rounding();
    int fe, cnt;
    clear_a();
    ifa.f_mat[0][0] = 64'h0000_0000_8000_0000;
    ifa.x_in[0]     = 64'h0000_0000_0000_0001;
    run_a(45, fe, cnt);
    checks++;
    if (ifa.x_pred[0] !== 64'd1) begin
      errors++; $display("FAIL round_half_pos: got %h expected 1", ifa.x_pred[0]);
    end
    ifa.x_in[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_a(45, fe, cnt);
    checks++;
    if (ifa.x_pred[0] !== 64'd0 || ifa.ovf !== 1'b0) begin
      errors++; $display("FAIL round_half_neg: got %h ovf %b expected 0 ovf 0", ifa.x_pred[0], ifa.ovf);
    end
  endtask

  task automatic test_busy_snapshot();
    int fe, cnt;
    fe = -1; cnt = 0;
    load_identity_a();
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ifa.done) begin
        if (fe < 0) fe = k;
        cnt++;
      end
      if (k == 4) begin
        for (int i = 0; i < 12; i++) ifa.x_in[i] = 64'(100 + i) << 32;
        ifa.start = 1'b1;
      end
      if (k == 5) ifa.start = 1'b0;
      if (k == 20) begin
        checks++;
        if (ifa.busy !== 1'b1) begin errors++; $display("FAIL snap_busy_mid: got %b expected 1", ifa.busy); end
      end
    end
    checks++;
    if (fe !== 40 || cnt !== 1) begin
      errors++; $display("FAIL snap_done: got edge %0d count %0d expected edge 40 count 1", fe, cnt);
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ifa.x_pred[i] !== 64'(i + 1) << 32) begin
        errors++; $display("FAIL snap_row%0d: got %h expected %h", i, ifa.x_pred[i], 64'(i + 1) << 32);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int fe, cnt;
    cnt = 0;
    load_identity_a();
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ifa.done) cnt++;
    end
    rst_a = 1'b1;
    #1;
    checks++;
    if ({ifa.busy, ifa.done, ifa.ovf} !== 3'b000 || ifa.x_pred !== '0) begin
      errors++; $display("FAIL midrst_state: got flags %b xpred %h expected 0",
                         {ifa.busy, ifa.done, ifa.ovf}, ifa.x_pred);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ifa.done || ifa.busy) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", cnt); end
    run_a(45, fe, cnt);
    checks++;
    if (fe !== 40 || cnt !== 1) begin
      errors++; $display("FAIL midrst_rerun_done: got edge %0d count %0d expected edge 40 count 1", fe, cnt);
    end
    checks++;
    if (ifa.x_pred[11] !== 64'd12 << 32 || ifa.x_pred[0] !== ONE) begin
      errors++; $display("FAIL midrst_rerun_rows: got %h/%h expected %h/%h",
                         ifa.x_pred[0], ifa.x_pred[11], ONE, 64'd12 << 32);
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, cnt;
    e1 = -1; e2 = -1; cnt = 0;
    load_identity_a();
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 95; k++) begin
      @(posedge clk); #1;
      if (ifa.done) begin
        if (cnt == 0) e1 = k;
        else if (cnt == 1) e2 = k;
        cnt++;
      end
      if (k == 81) ifa.start = 1'b0;
    end
    ifa.start = 1'b0;
    checks++;
    if (cnt !== 2 || e1 !== 40 || e2 !== 81) begin
      errors++; $display("FAIL b2b_done: got count %0d edges %0d,%0d expected 2 at 40,81", cnt, e1, e2);
    end
    checks++;
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b expected 0", ifa.busy); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bias_partial();
    test_saturation();
    test_rounding();
    test_busy_snapshot();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
